// File: rtl/state_profiler_pkg.sv
// Shared types and helpers for the state profiler: dump FSM encoding,
// saturating increment and index-width helper.
package state_profiler_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DUMP = 1'b1
  } fsm_e;

  // Counters up to 64 bits wide are supported by the helper.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/state_profiler_if.sv
// Readout handshake carrying one shadow counter word per transfer.
interface state_profiler_if #(
  parameter int CNT_W = 32,
  parameter int CH_W  = 2,
  parameter int ST_W  = 2
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;
  logic [CH_W-1:0]  rd_ch;
  logic [ST_W-1:0]  rd_state;
  logic             rd_last;

  modport master (
    output rd_valid, rd_data, rd_ch, rd_state, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_ch, rd_state, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/state_profiler_ch.sv
// One profiled channel: live bin counters, shadow bank and sticky
// out-of-range flag.
module state_profiler_ch
  import state_profiler_pkg::*;
#(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [STATE_W-1:0]                   state_i,
  input  logic                                 en_i,
  input  logic                                 clear_i,
  input  logic                                 capture_i,
  output logic [NUM_STATES-1:0][CNT_W-1:0]     shadow_o,
  output logic                                 err_o
);

  logic [NUM_STATES-1:0][CNT_W-1:0] live_q, live_d;
  logic [NUM_STATES-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_STATES-1:0][CNT_W-1:0] post_w;
  logic                             err_q, err_d;
  logic                             in_range;

  assign in_range = (32'(state_i) < NUM_STATES);

  // post_w is the live bank after this cycle's sample, before clear applies.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_bin
      logic hit;
      assign hit = en_i && in_range && (32'(state_i) == gi);
      assign post_w[gi] = hit ? CNT_W'(sat_inc(64'(live_q[gi]), CNT_W))
                              : live_q[gi];
    end
  endgenerate

  always_comb begin
    live_d   = clear_i ? '0 : post_w;
    shadow_d = shadow_q;
    // A simultaneous clear captures the pre-clear bank without the sample.
    if (capture_i) begin
      shadow_d = clear_i ? live_q : post_w;
    end
    err_d = err_q;
    if (clear_i) begin
      err_d = 1'b0;
    end else if (en_i && !in_range) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q   <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign shadow_o = shadow_q;
  assign err_o    = err_q;

endmodule

// File: rtl/state_profiler.sv
// Multi-channel state-occupancy profiler with snapshot dump over a
// valid/ready readout port.
module state_profiler
  import state_profiler_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*STATE_W-1:0]   state,
  input  logic                        en,
  input  logic                        clear,
  input  logic                        snap,
  output logic                        busy,
  output logic [NUM_CH-1:0]           err,
  state_profiler_if.master            rd
);

  localparam int CH_W = idx_w(NUM_CH);
  localparam int ST_W = idx_w(NUM_STATES);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [ST_W-1:0] LAST_ST = ST_W'(NUM_STATES - 1);

  fsm_e            fsm_q, fsm_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [ST_W-1:0] bin_q, bin_d;
  logic            capture;
  logic            xfer;
  logic            at_last;

  logic [NUM_CH-1:0][NUM_STATES-1:0][CNT_W-1:0] shadow_w;

  assign capture = (fsm_q == RUN) && snap;
  assign xfer    = (fsm_q == DUMP) && rd.rd_ready;
  assign at_last = (ch_q == LAST_CH) && (bin_q == LAST_ST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_profiler_ch #(
        .NUM_STATES (NUM_STATES),
        .STATE_W    (STATE_W),
        .CNT_W      (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .state_i   (state[gi*STATE_W +: STATE_W]),
        .en_i      (en),
        .clear_i   (clear),
        .capture_i (capture),
        .shadow_o  (shadow_w[gi]),
        .err_o     (err[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= RUN;
      ch_q  <= '0;
      bin_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      ch_q  <= ch_d;
      bin_q <= bin_d;
    end
  end

  // Word pointer walks channel-major and rewinds to (0,0) after the last word.
  always_comb begin
    fsm_d = fsm_q;
    ch_d  = ch_q;
    bin_d = bin_q;
    case (fsm_q)
      RUN: begin
        if (snap) begin
          fsm_d = DUMP;
          ch_d  = '0;
          bin_d = '0;
        end
      end
      DUMP: begin
        if (xfer) begin
          if (at_last) begin
            fsm_d = RUN;
            ch_d  = '0;
            bin_d = '0;
          end else if (bin_q == LAST_ST) begin
            bin_d = '0;
            ch_d  = ch_q + CH_W'(1);
          end else begin
            bin_d = bin_q + ST_W'(1);
          end
        end
      end
      default: fsm_d = RUN;
    endcase
  end

  always_comb begin
    busy        = (fsm_q == DUMP);
    rd.rd_valid = busy;
    rd.rd_last  = busy && at_last;
    rd.rd_ch    = ch_q;
    rd.rd_state = bin_q;
    rd.rd_data  = busy ? shadow_w[ch_q][bin_q] : '0;
  end

endmodule

// File: doc/state_profiler.md
STATE_PROFILER -- requirements
Module: state_profiler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of profiled channels (e.g. FIFOs).
REQ-002 SHALL have parameter NUM_STATES, default 3: number of state bins per channel (2..2**STATE_W).
REQ-003 SHALL have parameter STATE_W, default 2: width of one channel's state code.
REQ-004 SHALL have parameter CNT_W, default 32: width of each bin counter.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port state, input, NUM_CH*STATE_W: packed state codes; channel c occupies bits [c*STATE_W +: STATE_W].
REQ-008 SHALL have port en, input, 1: count enable; live counters update only when high.
REQ-009 SHALL have port clear, input, 1: synchronous zeroing of live counters and error flags.
REQ-010 SHALL have port snap, input, 1: single-cycle request to capture and dump all counters.
REQ-011 SHALL have port busy, output, 1: high while a dump is in progress.
REQ-012 SHALL have port rd_valid, input rd_ready, each 1: readout handshake.
REQ-013 SHALL have outputs rd_data (CNT_W), rd_ch ($clog2(NUM_CH), min 1), rd_state ($clog2(NUM_STATES), min 1) and rd_last (1): the current readout word.
REQ-014 SHALL have port err, output, NUM_CH: sticky per-channel out-of-range state flag.

Function
REQ-015 SHALL keep one live counter per (channel, bin), NUM_CH*NUM_STATES in total.
REQ-016 On each cycle with en=1 and clear=0, SHALL increment the counter of bin state[c] for every channel c.
REQ-017 Counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-018 A state code >= NUM_STATES SHALL increment no counter and SHALL set err[c], which stays set until clear or reset.
REQ-019 clear=1 SHALL zero all live counters and err on the next edge; that cycle's sample SHALL NOT be counted.
REQ-020 FSM SHALL have two states, RUN and DUMP; reset state is RUN.
REQ-021 RUN->DUMP on snap=1: SHALL copy into a shadow bank the live values as updated by that same cycle's sample.
REQ-022 Live counting SHALL continue unaffected during DUMP.
REQ-023 If snap and clear are both high, the shadow SHALL capture the pre-clear values, not including that cycle's sample; live counters then zero.
REQ-024 snap while busy=1 SHALL be ignored.
REQ-025 In DUMP, SHALL present shadow words in channel-major order (ch 0 bins 0..NUM_STATES-1, then ch 1, ...); the first word is valid the cycle after snap.
REQ-026 A word SHALL transfer on rd_valid & rd_ready; while rd_valid=1 and rd_ready=0, rd_data, rd_ch, rd_state and rd_last SHALL hold stable.
REQ-027 rd_last SHALL be high only on word (NUM_CH-1, NUM_STATES-1); its transfer SHALL return the FSM to RUN and drop busy and rd_valid the next cycle.
REQ-028 busy SHALL equal (FSM==DUMP); rd_valid SHALL be 0 in RUN.

Reset
REQ-029 Asserting rst (low) SHALL immediately zero all live and shadow counters and err, and force RUN, with busy=0, rd_valid=0, rd_last=0, rd_data=0, rd_ch=0 and rd_state=0.
REQ-030 Reset during DUMP SHALL abort the dump without any further readout word.
REQ-031 The first count SHALL occur on the first rising edge after rst deasserts with en=1.

Structure
REQ-032 A shared profiling package/header SHALL hold the FSM state encodings (RUN=0, DUMP=1) and the saturating-increment helper.
REQ-033 Per-channel counter, shadow and err logic SHALL be one sub-module, state_profiler_ch, instantiated NUM_CH times.
REQ-034 Readout mux and FSM SHALL live in the top module; no real types or $display SHALL be used; the block SHALL be fully synthesizable.

Verification (NUM_CH=2, NUM_STATES=3, STATE_W=2, CNT_W=8)
REQ-035 Ch0 state=1 and ch1 state=2 for 10 cycles with en=1, then snap with rd_ready=1 -> 6 words: (0,0)=0, (0,1)=11, (0,2)=0, (1,0)=0, (1,1)=0, (1,2)=11; rd_last only on the 6th word.
REQ-036 Ch0 state=0 for 300 cycles, then snap -> (0,0)=255 (saturated).
REQ-037 Ch1 state=3 for 5 cycles -> err=2'b10 and all ch1 bins 0; clear -> err=0.
REQ-038 rd_ready held low for 4 cycles mid-dump, and snap pulsed during dump -> stable outputs while stalled, snap ignored, word order unchanged, exactly 6 words.
REQ-039 snap and clear asserted together after 7 counted cycles -> dump shows 7; a later snap shows only counts accumulated after the clear.
REQ-040 rst asserted on the 3rd dump word -> outputs zero at once, busy=0, and no further words after release.
